// File: rtl/neuron_pkg.sv
// Shared types and helpers for the time-multiplexed fixed-point neuron.
// Holds the FSM state enum, default sizing, leaky slope and saturation helper.
package neuron_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_FRAC_W  = 8;
    localparam int DEF_MAX_LEN = 1024;
    localparam int LEAKY_SHIFT = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        DRAIN = 3'd2,
        ACT   = 3'd3,
        DONE  = 3'd4
    } neuron_state_t;

    // Clamp a signed value to the signed range of a w-bit word.
    // Works on a 64-bit carrier so callers of any width up to 63 bits can share it.
    function automatic logic signed [63:0] sat_to_data(
        input  logic signed [63:0] v,
        input  int unsigned        w,
        output logic               clip
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (w - 1));
        clip = 1'b0;
        sat_to_data = v;
        if (v > hi) begin
            sat_to_data = hi;
            clip        = 1'b1;
        end else if (v < lo) begin
            sat_to_data = lo;
            clip        = 1'b1;
        end
    endfunction

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Handshake bundle for neuron_mac_seq: job control, x/w input stream, result stream.
// master = job/stream source and result sink, slave = the neuron.
interface neuron_mac_seq_if
    import neuron_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = $clog2(DEF_MAX_LEN + 1)
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] bias;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_x;
    logic [DATA_W-1:0] in_w;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              sat_flag;

    modport master (
        output start, len, bias, in_valid, in_x, in_w, out_ready,
        input  busy, in_ready, out_valid, out_data, sat_flag
    );

    modport slave (
        input  start, len, bias, in_valid, in_x, in_w, out_ready,
        output busy, in_ready, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/neuron_activation.sv
// Combinational activation: rescale acc by FRAC_W, saturate to DATA_W, ReLU.
// Ports: acc_i (Q.2*FRAC_W accumulator), data_o (activated result), sat_o (clipped).
// Build option NEURON_LEAKY_RELU_EN: negatives become r >>> LEAKY_SHIFT instead of 0.
module neuron_activation
    import neuron_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ACC_W  = 2 * DEF_DATA_W + $clog2(DEF_MAX_LEN) + 1
) (
    input  logic [ACC_W-1:0]  acc_i,
    output logic [DATA_W-1:0] data_o,
    output logic              sat_o
);
    logic signed [63:0]       r_ext;
    logic signed [DATA_W-1:0] s_n;
    logic signed [DATA_W-1:0] leak;
    logic                     clip;

    always_comb begin
        r_ext  = {{(64 - ACC_W){acc_i[ACC_W-1]}}, acc_i};
        r_ext  = r_ext >>> FRAC_W;
        clip   = 1'b0;
        s_n    = DATA_W'(sat_to_data(r_ext, DATA_W, clip));
        leak   = s_n >>> LEAKY_SHIFT;
        sat_o  = clip;
        data_o = s_n;
        if (s_n[DATA_W-1]) begin
`ifdef NEURON_LEAKY_RELU_EN
            data_o = leak;
`else
            data_o = '0;
`endif
        end
    end
endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed fixed-point neuron: one multiplier steps through len (x, w)
// pairs, adds bias, then rescales, saturates and applies ReLU to the result.
// Ports: clk, reset (async active-high), bus (slave side of neuron_mac_seq_if).
// Build option NEURON_LEAKY_RELU_EN selects leaky ReLU in neuron_activation.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int ACC_W   = 2 * DATA_W + $clog2(MAX_LEN) + 1
) (
    input logic             clk,
    input logic             reset,
    neuron_mac_seq_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W;

    neuron_state_t      state_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [PROD_W-1:0]  prod_q;
    logic               prod_v_q;
    logic [DATA_W-1:0]  out_data_q;
    logic               sat_q;
    logic               out_valid_q;

    logic               beat;
    logic [PROD_W-1:0]  prod_d;
    logic [ACC_W-1:0]   bias_ext;
    logic [DATA_W-1:0]  act_data;
    logic               act_sat;

    assign beat     = (state_q == ACCUM) && bus.in_valid;
    assign prod_d   = PROD_W'($signed(bus.in_x) * $signed(bus.in_w));
    assign bias_ext = {{(ACC_W - DATA_W){bus.bias[DATA_W-1]}}, bus.bias};

    // Second pipeline step: a registered product lands in acc one cycle later.
    always_comb begin
        acc_d = acc_q;
        if (prod_v_q) begin
            acc_d = acc_q + {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
        end
    end

    neuron_activation #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_act (
        .acc_i  (acc_q),
        .data_o (act_data),
        .sat_o  (act_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            prod_v_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cnt_q   <= bus.len;
                        acc_q   <= bias_ext <<< FRAC_W;
                        state_q <= (bus.len != '0) ? ACCUM : DRAIN;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        prod_q   <= prod_d;
                        prod_v_q <= 1'b1;
                        cnt_q    <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Hold while the last product is still in flight so ACT
                    // always sees the complete sum.
                    if (!prod_v_q) begin
                        state_q <= ACT;
                    end
                end
                ACT: begin
                    out_data_q  <= act_data;
                    sat_q       <= act_sat;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.sat_flag  = sat_q;

    a_len_legal: assert property (
        @(posedge clk) disable iff (reset)
        (state_q == IDLE && bus.start) |-> (bus.len <= LEN_W'(MAX_LEN))
    );
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: directed plan plus random jobs
// against a plain-arithmetic reference model.
module tb_neuron_mac_seq;
    localparam int DW = 16;
    localparam int LW = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] xs[16];
    logic [15:0] ws[16];

    neuron_mac_seq_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

    neuron_mac_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int n, input logic [15:0] b,
                                  output logic [15:0] d, output logic s);
        longint acc;
        longint r;
        acc = longint'($signed(b)) * 256;
        for (int i = 0; i < n; i++)
            acc += longint'($signed(xs[i])) * longint'($signed(ws[i]));
        r = acc >>> 8;
        s = 1'b0;
        if (r > 32767) begin
            r = 32767;
            s = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            s = 1'b1;
        end
        if (r < 0) begin
`ifdef NEURON_LEAKY_RELU_EN
            r = r >>> 3;
`else
            r = 0;
`endif
        end
        d = r[15:0];
    endfunction

    task automatic job(input int n, input logic [15:0] b, input bit gaps,
                       input int stall, input string tag);
        logic [15:0] ed;
        logic        es;
        int          ref_e;
        bit          got;
        bit          saw_rdy;
        model(n, b, ed, es);
        bus.start = 1'b1;
        bus.len   = LW'(n);
        bus.bias  = b;
        @(negedge clk);
        bus.start = 1'b0;
        ref_e = cyc;
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_x     = xs[i];
            bus.in_w     = ws[i];
            chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
            @(negedge clk);
            ref_e = cyc;
            bus.in_valid = 1'b0;
        end
        got     = 1'b0;
        saw_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            if (bus.in_ready) saw_rdy = 1'b1;
            @(negedge clk);
        end
        chk({tag, ".out_valid"}, 32'(got), 32'd1);
        chk({tag, ".latency"}, 32'(cyc - ref_e), (n > 0) ? 32'd3 : 32'd2);
        chk({tag, ".ready_after"}, 32'(saw_rdy), 32'd0);
        chk({tag, ".data"}, 32'(bus.out_data), 32'(ed));
        chk({tag, ".sat"}, 32'(bus.sat_flag), 32'(es));
        for (int s = 0; s < stall; s++) begin
            bus.start    = 1'b1;
            bus.len      = LW'(1);
            bus.in_valid = 1'b1;
            bus.in_x     = 16'($urandom);
            @(negedge clk);
            chk({tag, ".hold_data"}, 32'(bus.out_data), 32'(ed));
            chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_rdy"}, 32'(bus.in_ready), 32'd0);
            chk({tag, ".hold_busy"}, 32'(bus.busy), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.start     = (stall > 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk({tag, ".valid_clr"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [15:0] d_gap;
        int          n;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.bias      = '0;
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_w      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.out_data", 32'(bus.out_data), 32'd0);
        chk("rst.sat", 32'(bus.sat_flag), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        xs[0] = 16'h0100; ws[0] = 16'h0200;
        job(1, 16'h0080, 1'b0, 0, "basic");
        chk("basic.const", 32'(bus.out_data), 32'h0280);

        xs[0] = 16'h0100; ws[0] = 16'hFF00;
        xs[1] = 16'h0100; ws[1] = 16'hFF00;
        job(2, 16'h0000, 1'b0, 0, "neg");
`ifdef NEURON_LEAKY_RELU_EN
        chk("neg.const", 32'(bus.out_data), 32'hFFC0);
`else
        chk("neg.const", 32'(bus.out_data), 32'h0000);
`endif

        for (int i = 0; i < 4; i++) begin
            xs[i] = 16'h7FFF;
            ws[i] = 16'h7FFF;
        end
        job(4, 16'h0000, 1'b0, 0, "sat");
        chk("sat.const", 32'(bus.out_data), 32'h7FFF);
        chk("sat.flag", 32'(bus.sat_flag), 32'd1);

        job(0, 16'h0100, 1'b0, 0, "len0");
        chk("len0.const", 32'(bus.out_data), 32'h0100);

        for (int i = 0; i < 3; i++) begin
            xs[i] = 16'($urandom_range(0, 16'h07FF)) - 16'h0400;
            ws[i] = 16'($urandom_range(0, 16'h07FF)) - 16'h0400;
        end
        job(3, 16'h0040, 1'b1, 5, "bp");
        d_gap = bus.out_data;
        job(3, 16'h0040, 1'b0, 0, "nogap");
        chk("bp.equal", 32'(bus.out_data), 32'(d_gap));

        for (int i = 0; i < 4; i++) begin
            xs[i] = 16'h0200;
            ws[i] = 16'h0300;
        end
        bus.start = 1'b1;
        bus.len   = LW'(4);
        bus.bias  = 16'h0010;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_x     = xs[i];
            bus.in_w     = ws[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.in_ready", 32'(bus.in_ready), 32'd0);
        chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort.out_data", 32'(bus.out_data), 32'd0);
        chk("abort.sat", 32'(bus.sat_flag), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        xs[0] = 16'h0100; ws[0] = 16'h0100;
        job(1, 16'h0000, 1'b0, 0, "after_rst");
        chk("after_rst.const", 32'(bus.out_data), 32'h0100);

        for (int j = 0; j < 12; j++) begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0) begin
                    xs[i] = 16'($urandom_range(0, 16'h07FF)) - 16'h0400;
                    ws[i] = 16'($urandom_range(0, 16'h07FF)) - 16'h0400;
                end else begin
                    xs[i] = 16'($urandom);
                    ws[i] = 16'($urandom);
                end
            end
            job(n, 16'($urandom), bit'($urandom_range(0, 1)),
                $urandom_range(0, 2), $sformatf("rnd%0d", j));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
